// File: rtl/debug_unit_if.sv
// debug_unit_if
// Bundles the signals exchanged between the debug unit and the CPU it controls.
//   master (debug unit side):
//     cpu_run        out  CPU clock enable
//     cpu_sel0       out  3-bit stage/view select for the CPU
//     cpu_sel1       out  2-bit page within the selected stage
//     cpu_m_rf_addr  out  word-aligned byte address for memory/regfile scan
//     cpu_status     in   32-bit status word for the current sel0/sel1
//     cpu_ctrl       in   16-bit control-signal word for the current sel0
//     cpu_m_data     in   data-memory read word at cpu_m_rf_addr
//     cpu_r_data     in   register-file read word at cpu_m_rf_addr[6:2]
//   slave (CPU side): same signals, opposite directions.
interface debug_unit_if;
    logic        cpu_run;
    logic [2:0]  cpu_sel0;
    logic [1:0]  cpu_sel1;
    logic [31:0] cpu_m_rf_addr;
    logic [31:0] cpu_status;
    logic [15:0] cpu_ctrl;
    logic [31:0] cpu_m_data;
    logic [31:0] cpu_r_data;

    modport master (
        output cpu_run, cpu_sel0, cpu_sel1, cpu_m_rf_addr,
        input  cpu_status, cpu_ctrl, cpu_m_data, cpu_r_data
    );

    modport slave (
        input  cpu_run, cpu_sel0, cpu_sel1, cpu_m_rf_addr,
        output cpu_status, cpu_ctrl, cpu_m_data, cpu_r_data
    );
endinterface

// File: rtl/debug_unit.sv
// debug_unit
// Front-panel debug controller for a pipelined CPU: gates the CPU clock
// (continuous run or single step), walks a data-memory/register-file scan
// address or a pipeline-stage page, and drives LEDs and a seven-segment word.
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   succ      in   continuous-run request (level)
//   step      in   single-step request (level, rising edge acted on)
//   sel       in   3-bit view: 0 = memory/regfile scan, 1..5 = stage pages
//   m_rf      in   scan space: 1 = data memory, 0 = register file
//   inc, dec  in   pre-synchronized levels; rising edge advances/retreats
//   cpu       if   debug_unit_if.master bundle towards the CPU
//   led       out  16-bit LED word (registered)
//   seg_data  out  32-bit seven-segment word (registered)
module debug_unit #(
    parameter logic [31:0] MEM_ADDR_MAX = 32'h0000_03FC,
    parameter logic [31:0] RF_ADDR_MAX  = 32'h0000_007C
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         succ,
    input  logic         step,
    input  logic [2:0]   sel,
    input  logic         m_rf,
    input  logic         inc,
    input  logic         dec,
    debug_unit_if.master cpu,
    output logic [15:0]  led,
    output logic [31:0]  seg_data
);

    typedef enum logic [1:0] {
        HALT,
        RUN,
        STEP,
        WAIT_REL
    } run_state_t;

    run_state_t  state;
    run_state_t  state_next;

    logic        step_q;
    logic        inc_q;
    logic        dec_q;
    logic        m_rf_q;
    logic        armed;
    logic        step_edge;
    logic        inc_edge;
    logic        dec_edge;
    logic [31:0] addr_q;
    logic [31:0] addr_limit;
    logic [1:0]  page_q;
    logic        scan_view;

    assign scan_view = (sel == 3'd0);

    // History registers are cleared by reset, so a button held through reset
    // release would look like a fresh press on the first cycle. 'armed' masks
    // edges for that one cycle so a held button only acts after a real release.
    assign step_edge = armed & step & ~step_q;
    assign inc_edge  = armed & inc  & ~inc_q;
    assign dec_edge  = armed & dec  & ~dec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= 1'b0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            m_rf_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            step_q <= step;
            inc_q  <= inc;
            dec_q  <= dec;
            m_rf_q <= m_rf;
            armed  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HALT;
        end else begin
            state <= state_next;
        end
    end

    // Scan view (sel = 0) always freezes the CPU; the clock enable is a pure
    // decode of the registered state, so reset drops it at the same edge.
    always_comb begin
        state_next = state;
        case (state)
            HALT: begin
                if (succ) begin
                    state_next = RUN;
                end else if (step_edge) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                if (!succ) begin
                    state_next = HALT;
                end
            end
            STEP: begin
                state_next = WAIT_REL;
            end
            WAIT_REL: begin
                if (!step) begin
                    state_next = HALT;
                end
            end
            default: begin
                state_next = HALT;
            end
        endcase
        if (scan_view) begin
            state_next = HALT;
        end
        cpu.cpu_run = (state == RUN) || (state == STEP);
    end

    // cpu_sel0 doubles as the previous-sel register used to spot view changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu.cpu_sel0 <= 3'd0;
        end else begin
            cpu.cpu_sel0 <= sel;
        end
    end

    assign addr_limit = m_rf ? MEM_ADDR_MAX : RF_ADDR_MAX;

    // A change of scan space clears the address even outside the scan view,
    // so the address can never sit beyond the limit of the new space.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= 32'd0;
        end else if (m_rf != m_rf_q) begin
            addr_q <= 32'd0;
        end else if (scan_view && inc_edge && !dec_edge) begin
            addr_q <= (addr_q >= addr_limit) ? 32'd0 : addr_q + 32'd4;
        end else if (scan_view && dec_edge && !inc_edge) begin
            addr_q <= (addr_q == 32'd0) ? addr_limit : addr_q - 32'd4;
        end
    end

    assign cpu.cpu_m_rf_addr = addr_q;

    // Page counter wraps naturally in two bits; any view change restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            page_q <= 2'd0;
        end else if (sel != cpu.cpu_sel0) begin
            page_q <= 2'd0;
        end else if (!scan_view && inc_edge && !dec_edge) begin
            page_q <= page_q + 2'd1;
        end else if (!scan_view && dec_edge && !inc_edge) begin
            page_q <= page_q - 2'd1;
        end
    end

    assign cpu.cpu_sel1 = page_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            led      <= 16'd0;
            seg_data <= 32'd0;
        end else if (scan_view) begin
            led      <= {8'h00, addr_q[9:2]};
            seg_data <= m_rf ? cpu.cpu_m_data : cpu.cpu_r_data;
        end else begin
            led      <= cpu.cpu_ctrl;
            seg_data <= cpu.cpu_status;
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit
// Drives debug_unit through the documented front-panel scenarios with literal
// expectations, then a randomized phase. A behavioural model tracks what every
// output must be and is compared on every cycle.
module tb_debug_unit;

    localparam logic [31:0] MEM_MAX = 32'h0000_03FC;
    localparam logic [31:0] RF_MAX  = 32'h0000_007C;

    logic        clk;
    logic        rst_in;
    logic        succ_in;
    logic        step_in;
    logic [2:0]  sel_in;
    logic        m_rf_in;
    logic        inc_in;
    logic        dec_in;
    logic [31:0] status_in;
    logic [15:0] ctrl_in;
    logic [31:0] mdata_in;
    logic [31:0] rdata_in;
    logic [15:0] led;
    logic [31:0] seg_data;

    int checks = 0;
    int errors = 0;

    debug_unit_if cpu_bus ();

    assign cpu_bus.cpu_status = status_in;
    assign cpu_bus.cpu_ctrl   = ctrl_in;
    assign cpu_bus.cpu_m_data = mdata_in;
    assign cpu_bus.cpu_r_data = rdata_in;

    debug_unit #(
        .MEM_ADDR_MAX (MEM_MAX),
        .RF_ADDR_MAX  (RF_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst_in),
        .succ     (succ_in),
        .step     (step_in),
        .sel      (sel_in),
        .m_rf     (m_rf_in),
        .inc      (inc_in),
        .dec      (dec_in),
        .cpu      (cpu_bus),
        .led      (led),
        .seg_data (seg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Run behaviour as flags: free-running, one-cycle pulse, waiting for release.
    bit          m_running, m_pulsing, m_waiting;
    bit          p_step, p_inc, p_dec, p_mrf, m_armed;
    bit          se, ie, de;
    logic [31:0] m_addr;
    logic [1:0]  m_page;
    logic [2:0]  m_sel0;
    logic [15:0] m_led;
    logic [31:0] m_seg;
    int          words, idx;

    always @(posedge clk) begin
        if (rst_in) begin
            m_running = 0; m_pulsing = 0; m_waiting = 0;
            p_step = 0; p_inc = 0; p_dec = 0; p_mrf = 0; m_armed = 0;
            m_addr = 0; m_page = 0; m_sel0 = 0; m_led = 0; m_seg = 0;
        end else begin
            se = m_armed && step_in && !p_step;
            ie = m_armed && inc_in && !p_inc;
            de = m_armed && dec_in && !p_dec;

            if (sel_in == 0) begin
                m_led = {8'h00, m_addr[9:2]};
                m_seg = m_rf_in ? mdata_in : rdata_in;
            end else begin
                m_led = ctrl_in;
                m_seg = status_in;
            end

            if (sel_in == 0) begin
                m_running = 0; m_pulsing = 0; m_waiting = 0;
            end else if (m_running) begin
                m_running = succ_in;
            end else if (m_pulsing) begin
                m_pulsing = 0; m_waiting = 1;
            end else if (m_waiting) begin
                m_waiting = step_in;
            end else if (succ_in) begin
                m_running = 1;
            end else if (se) begin
                m_pulsing = 1;
            end

            if (m_rf_in != p_mrf) begin
                m_addr = 0;
            end else if (sel_in == 0 && ie != de) begin
                words = int'((m_rf_in ? MEM_MAX : RF_MAX) / 4) + 1;
                idx = int'(m_addr / 4);
                idx = ie ? (idx + 1) % words : (idx + words - 1) % words;
                m_addr = 32'(idx * 4);
            end

            if (sel_in != m_sel0) m_page = 0;
            else if (sel_in != 0 && ie != de) m_page = ie ? m_page + 2'd1 : m_page - 2'd1;

            m_sel0 = sel_in;
            p_step = step_in; p_inc = inc_in; p_dec = dec_in; p_mrf = m_rf_in;
            m_armed = 1;
        end
        #1;
        checkOutput("cpu_run", {31'd0, cpu_bus.cpu_run}, {31'd0, (m_running || m_pulsing)});
        checkOutput("cpu_sel0", {29'd0, cpu_bus.cpu_sel0}, {29'd0, m_sel0});
        checkOutput("cpu_sel1", {30'd0, cpu_bus.cpu_sel1}, {30'd0, m_page});
        checkOutput("addr", cpu_bus.cpu_m_rf_addr, m_addr);
        checkOutput("led", {16'd0, led}, {16'd0, m_led});
        checkOutput("seg_data", seg_data, m_seg);
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic inc_pulse();
        inc_in = 1; cycle();
        inc_in = 0; cycle();
    endtask

    task automatic applyStimulus();
        rst_in = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 29) == 0)
            sel_in = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 5));
        if ($urandom_range(0, 14) == 0) succ_in = ~succ_in;
        if ($urandom_range(0, 3) == 0)  step_in = ~step_in;
        if ($urandom_range(0, 2) == 0)  inc_in = ~inc_in;
        if ($urandom_range(0, 2) == 0)  dec_in = ~dec_in;
        if ($urandom_range(0, 39) == 0) m_rf_in = ~m_rf_in;
        status_in = $urandom;
        ctrl_in   = 16'($urandom);
        mdata_in  = $urandom;
        rdata_in  = $urandom;
    endtask

    int run_count;

    initial begin
        rst_in = 1; succ_in = 0; step_in = 0; sel_in = 0; m_rf_in = 0;
        inc_in = 0; dec_in = 0; status_in = 0; ctrl_in = 0; mdata_in = 0; rdata_in = 0;
        cycle(); cycle();
        checkOutput("reset cpu_run", {31'd0, cpu_bus.cpu_run}, 32'd0);
        checkOutput("reset addr", cpu_bus.cpu_m_rf_addr, 32'd0);
        checkOutput("reset seg", seg_data, 32'd0);

        // Register-file scan: 31 steps to the top, wrap both ways
        rst_in = 0; cycle();
        for (int i = 0; i < 31; i++) inc_pulse();
        checkOutput("rf addr top", cpu_bus.cpu_m_rf_addr, 32'h7C);
        checkOutput("rf led top", {16'd0, led}, 32'h001F);
        inc_pulse();
        checkOutput("rf wrap up", cpu_bus.cpu_m_rf_addr, 32'h00);
        dec_in = 1; cycle(); dec_in = 0; cycle();
        checkOutput("rf wrap down", cpu_bus.cpu_m_rf_addr, 32'h7C);

        // Memory scan, space change overrides inc, simultaneous inc+dec holds
        m_rf_in = 1; cycle();
        checkOutput("mrf change clears", cpu_bus.cpu_m_rf_addr, 32'h00);
        for (int i = 0; i < 4; i++) inc_pulse();
        checkOutput("mem addr 0x10", cpu_bus.cpu_m_rf_addr, 32'h10);
        mdata_in = 32'h1234_5678; rdata_in = 32'hCAFE_F00D; cycle();
        checkOutput("seg mem data", seg_data, 32'h1234_5678);
        m_rf_in = 0; inc_in = 1; cycle();
        checkOutput("mrf change beats inc", cpu_bus.cpu_m_rf_addr, 32'h00);
        checkOutput("seg rf data", seg_data, 32'hCAFE_F00D);
        inc_in = 0; cycle();
        inc_pulse();
        inc_in = 1; dec_in = 1; cycle();
        checkOutput("inc+dec hold", cpu_bus.cpu_m_rf_addr, 32'h04);
        inc_in = 0; dec_in = 0; cycle();

        // Single step: held press gives one pulse, second press gives another
        for (int press = 0; press < 2; press++) begin
            sel_in = 1; step_in = 1; run_count = 0;
            for (int i = 0; i < 10; i++) begin
                cycle();
                if (cpu_bus.cpu_run) run_count++;
            end
            checkOutput("step pulse count", 32'(run_count), 32'd1);
            step_in = 0; cycle(); cycle();
        end
        checkOutput("sel0 follows sel", {29'd0, cpu_bus.cpu_sel0}, 32'd1);

        // Continuous run, stopped by switching to the scan view
        sel_in = 2; succ_in = 1; run_count = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (cpu_bus.cpu_run) run_count++;
        end
        checkOutput("run cycles", 32'(run_count), 32'd20);
        sel_in = 0; cycle();
        checkOutput("scan stops run", {31'd0, cpu_bus.cpu_run}, 32'd0);
        succ_in = 0;

        // Pages: dec wraps to 3, view change clears, status reaches the display
        sel_in = 3; cycle();
        dec_in = 1; cycle();
        checkOutput("page wrap down", {30'd0, cpu_bus.cpu_sel1}, 32'd3);
        dec_in = 0; sel_in = 4; cycle();
        checkOutput("sel change clears page", {30'd0, cpu_bus.cpu_sel1}, 32'd0);
        status_in = 32'hDEAD_BEEF; cycle();
        checkOutput("seg status", seg_data, 32'hDEAD_BEEF);
        status_in = 0;

        // Reset during RUN, run resumes once reset is released
        sel_in = 2; succ_in = 1; cycle(); cycle();
        checkOutput("running before reset", {31'd0, cpu_bus.cpu_run}, 32'd1);
        rst_in = 1; cycle();
        checkOutput("reset kills run", {31'd0, cpu_bus.cpu_run}, 32'd0);
        checkOutput("reset sel0", {29'd0, cpu_bus.cpu_sel0}, 32'd0);
        checkOutput("reset led", {16'd0, led}, 32'd0);
        rst_in = 0; cycle();
        checkOutput("run after reset", {31'd0, cpu_bus.cpu_run}, 32'd1);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            cycle();
        end

        rst_in = 0;
        cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 Parameter MEM_ADDR_MAX, 32'h0000_03FC, highest byte address of data-memory scan space (256 words).
REQ-002 Parameter RF_ADDR_MAX, 32'h0000_007C, highest byte address of register-file scan space (32 regs).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 succ  input  1  level, continuous-run request.
REQ-006 step  input  1  level, single-step request; acted on at rising edge.
REQ-007 sel  input  3  view select; 0 = memory/regfile scan, 1..5 = CPU pipeline-stage pages.
REQ-008 m_rf  input  1  scan space; 1 = data memory, 0 = register file.
REQ-009 inc  input  1  level, pre-synchronized; rising edge advances address or page.
REQ-010 dec  input  1  level, pre-synchronized; rising edge retreats address or page.
REQ-011 cpu_status  input  32  CPU status word for current sel0/sel1.
REQ-012 cpu_ctrl  input  16  CPU control-signal word for current sel0.
REQ-013 cpu_m_data  input  32  CPU data-memory read word at cpu_m_rf_addr.
REQ-014 cpu_r_data  input  32  CPU register-file read word at cpu_m_rf_addr[6:2].
REQ-015 cpu_run  output  1  CPU clock enable.
REQ-016 cpu_sel0  output  3  drives CPU sel0.
REQ-017 cpu_sel1  output  2  drives CPU sel1 (page within stage).
REQ-018 cpu_m_rf_addr  output  32  drives CPU m_rf_addr; always word-aligned.
REQ-019 led  output  16  display LEDs.
REQ-020 seg_data  output  32  seven-segment display word.

Function
REQ-021 Edge detect: step/inc/dec each registered once; edge = current & ~previous; level held high yields exactly one edge.
REQ-022 Run FSM states HALT, RUN, STEP, WAIT_REL; cpu_run = 1 in RUN and STEP only.
REQ-023 HALT -> RUN when succ=1 and sel!=0; RUN -> HALT when succ=0 or sel=0.
REQ-024 HALT -> STEP on step edge when succ=0 and sel!=0; succ has priority over step.
REQ-025 STEP -> WAIT_REL unconditionally; cpu_run high exactly one cycle per step press.
REQ-026 WAIT_REL -> HALT when step=0; step edges while in RUN, STEP or WAIT_REL are discarded.
REQ-027 sel=0 forces next state HALT from any state (CPU frozen during memory/regfile scan).
REQ-028 cpu_sel0 = sel registered, one-cycle latency.
REQ-029 Address counter (sel=0 only): inc edge adds 4, dec edge subtracts 4; limit = MEM_ADDR_MAX if m_rf=1 else RF_ADDR_MAX.
REQ-030 inc at limit wraps to 0; dec at 0 wraps to limit.
REQ-031 Change of m_rf (registered compare) clears address to 0 that cycle, overriding inc/dec.
REQ-032 Page counter (sel!=0 only): cpu_sel1 inc edge +1, dec edge -1, 2-bit modulo wrap (3->0, 0->3).
REQ-033 Change of sel clears cpu_sel1 to 0 that cycle, overriding inc/dec.
REQ-034 Simultaneous inc and dec edges in the same cycle: no change to either counter.
REQ-035 Address and page counters hold when their sel condition is not met.
REQ-036 seg_data registered: sel=0 -> cpu_m_data if m_rf=1 else cpu_r_data; sel!=0 -> cpu_status.
REQ-037 led registered: sel=0 -> {8'h00, cpu_m_rf_addr[9:2]}; sel!=0 -> cpu_ctrl.

Reset
REQ-038 rst=1 at a clock edge: state HALT, cpu_run 0, cpu_sel0 0, cpu_sel1 0, cpu_m_rf_addr 0, led 0, seg_data 0, all edge/compare history registers 0.
REQ-039 rst mid-RUN or mid-STEP deasserts cpu_run at the same edge; a step held through reset release produces no step.

Verification
REQ-040 sel=1, step 0->1 held 10 cycles -> cpu_run high exactly 1 cycle; release then press again -> second single pulse.
REQ-041 sel=2, succ=1 for 20 cycles then sel=0 -> cpu_run high continuously, low from the cycle after sel=0 is registered.
REQ-042 sel=0, m_rf=0, 31 inc edges -> addr 0x7C; one more -> 0x00; one dec -> 0x7C.
REQ-043 sel=0, m_rf=1, addr 0x10, toggle m_rf=0 together with inc edge -> addr 0x00; simultaneous inc+dec -> unchanged.
REQ-044 sel=3, dec edge -> cpu_sel1 3; change sel to 4 -> cpu_sel1 0; cpu_status=32'hDEADBEEF -> seg_data 32'hDEADBEEF one cycle later.
REQ-045 succ=1 in RUN, rst pulsed 1 cycle -> all outputs 0 after edge; FSM re-enters RUN next cycle since succ still 1.
